// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the memory arbiter.
// The arbiter uses the slave view; the pipeline/memory environment uses the master view.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic              I_req_in;
   logic [AW-1:0]     I_addr_in;
   logic [DW-1:0]     I_rdata_out;
   logic              I_busy_out;
   logic              D_req_in;
   logic              D_wr_in;
   logic [DW/8-1:0]   D_be_in;
   logic [AW-1:0]     D_addr_in;
   logic [DW-1:0]     D_wdata_in;
   logic [DW-1:0]     D_rdata_out;
   logic              D_busy_out;
   logic              M_req_out;
   logic              M_gnt_in;
   logic              M_wr_out;
   logic [DW/8-1:0]   M_be_out;
   logic [AW-1:0]     M_addr_out;
   logic [DW-1:0]     M_wdata_out;
   logic [DW-1:0]     M_rdata_in;
   logic              M_rvalid_in;
   logic              ERR_timeout_out;

   modport slave (
      input  I_req_in, I_addr_in,
      output I_rdata_out, I_busy_out,
      input  D_req_in, D_wr_in, D_be_in, D_addr_in, D_wdata_in,
      output D_rdata_out, D_busy_out,
      output M_req_out, M_wr_out, M_be_out, M_addr_out, M_wdata_out,
      input  M_gnt_in, M_rdata_in, M_rvalid_in,
      output ERR_timeout_out
   );

   modport master (
      output I_req_in, I_addr_in,
      input  I_rdata_out, I_busy_out,
      output D_req_in, D_wr_in, D_be_in, D_addr_in, D_wdata_in,
      input  D_rdata_out, D_busy_out,
      input  M_req_out, M_wr_out, M_be_out, M_addr_out, M_wdata_out,
      output M_gnt_in, M_rdata_in, M_rvalid_in,
      input  ERR_timeout_out
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data accesses,
// one transaction at a time, with data priority bounded by a starvation counter.
module mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic         CLK,
   input  logic         RSTn,
   mem_arbiter_if.slave bus
);
   localparam int BW = DW / 8;
   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      IDLE, REQ_I, WAIT_I, DONE_I, REQ_D, WAIT_D, DONE_D
   } state_t;

   state_t          state_q, state_d;
   logic            m_req_q, m_req_d;
   logic            m_wr_q, m_wr_d;
   logic [BW-1:0]   m_be_q, m_be_d;
   logic [AW-1:0]   m_addr_q, m_addr_d;
   logic [DW-1:0]   m_wdata_q, m_wdata_d;
   logic [DW-1:0]   i_rdata_q, i_rdata_d;
   logic [DW-1:0]   d_rdata_q, d_rdata_d;
   logic            err_q, err_d;
   logic [3:0]      starve_q, starve_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            starveFull;
   logic            tmoHit;

   assign starveFull = (starve_q == 4'(STARVE_MAX));
   assign tmoHit     = (tmo_q == TW'(TIMEOUT - 1));

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q   <= IDLE;
         m_req_q   <= 1'b0;
         m_wr_q    <= 1'b0;
         m_be_q    <= '0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         err_q     <= 1'b0;
         starve_q  <= '0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         m_req_q   <= m_req_d;
         m_wr_q    <= m_wr_d;
         m_be_q    <= m_be_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         err_q     <= err_d;
         starve_q  <= starve_d;
         tmo_q     <= tmo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      m_req_d   = m_req_q;
      m_wr_d    = m_wr_q;
      m_be_d    = m_be_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      err_d     = err_q;
      starve_d  = starve_q;
      tmo_d     = '0;
      unique case (state_q)
         IDLE: begin
            starve_d = '0;
            // Data wins unless fetch has already been passed over STARVE_MAX times in a row.
            if (bus.D_req_in && !(bus.I_req_in && starveFull)) begin
               state_d   = REQ_D;
               m_req_d   = 1'b1;
               m_wr_d    = bus.D_wr_in;
               m_be_d    = bus.D_be_in;
               m_addr_d  = bus.D_addr_in;
               m_wdata_d = bus.D_wdata_in;
               if (bus.I_req_in) begin
                  starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 1'b1;
               end
            end else if (bus.I_req_in) begin
               state_d   = REQ_I;
               m_req_d   = 1'b1;
               m_wr_d    = 1'b0;
               m_be_d    = '1;
               m_addr_d  = bus.I_addr_in;
               m_wdata_d = '0;
            end
         end
         REQ_I, REQ_D: begin
            tmo_d = tmo_q + 1'b1;
            if (bus.M_gnt_in) begin
               m_req_d = 1'b0;
               state_d = (state_q == REQ_I) ? WAIT_I : WAIT_D;
            end else if (tmoHit) begin
               m_req_d = 1'b0;
               err_d   = 1'b1;
               if (state_q == REQ_I) begin
                  i_rdata_d = '0;
                  state_d   = DONE_I;
               end else begin
                  d_rdata_d = '0;
                  state_d   = DONE_D;
               end
            end
         end
         WAIT_I: begin
            tmo_d = tmo_q + 1'b1;
            if (bus.M_rvalid_in) begin
               i_rdata_d = bus.M_rdata_in;
               state_d   = DONE_I;
            end else if (tmoHit) begin
               err_d     = 1'b1;
               i_rdata_d = '0;
               state_d   = DONE_I;
            end
         end
         WAIT_D: begin
            tmo_d = tmo_q + 1'b1;
            // Write completions carry no data, so the previous load result is kept.
            if (bus.M_rvalid_in) begin
               if (!m_wr_q) d_rdata_d = bus.M_rdata_in;
               state_d = DONE_D;
            end else if (tmoHit) begin
               err_d     = 1'b1;
               d_rdata_d = '0;
               state_d   = DONE_D;
            end
         end
         DONE_I, DONE_D: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.I_busy_out      = RSTn && bus.I_req_in && (state_q != DONE_I);
   assign bus.D_busy_out      = RSTn && bus.D_req_in && (state_q != DONE_D);
   assign bus.I_rdata_out     = i_rdata_q;
   assign bus.D_rdata_out     = d_rdata_q;
   assign bus.M_req_out       = m_req_q;
   assign bus.M_wr_out        = m_wr_q;
   assign bus.M_be_out        = m_be_q;
   assign bus.M_addr_out      = m_addr_q;
   assign bus.M_wdata_out     = m_wdata_q;
   assign bus.ERR_timeout_out = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single accesses plus
// hand-written arbitration, reset, delayed-grant and timeout sequences.
module tb_mem_arbiter;
   logic CLK;
   logic RSTn;

   int checks   = 0;
   int failures = 0;

   int          gntDelay  = 0;
   int          rvDelay   = 1;
   logic [31:0] memRdata  = '0;
   bit          memOn     = 1'b1;

   typedef struct {
      bit          isD;
      bit          wr;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] memData;
      int          gd;
      int          rd;
      int          expBusy;
      logic [31:0] expRdata;
      bit          expWr;
      logic [3:0]  expBe;
      logic [31:0] expAddr;
      logic [31:0] expWdata;
   } vec_t;

   vec_t vecs[5];

   mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(64)) dut (
      .CLK (CLK),
      .RSTn(RSTn),
      .bus (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory model: grants after gntDelay request cycles, completes rvDelay cycles after the grant.
   initial begin
      int  gntCnt;
      int  rvCnt;
      bit  rvPending;
      gntCnt    = 0;
      rvCnt     = 0;
      rvPending = 1'b0;
      bus.M_gnt_in    = 1'b0;
      bus.M_rvalid_in = 1'b0;
      bus.M_rdata_in  = '0;
      forever begin
         @(posedge CLK);
         #1;
         bus.M_gnt_in    = 1'b0;
         bus.M_rvalid_in = 1'b0;
         if (rvPending) begin
            if (rvCnt == 0) begin
               bus.M_rvalid_in = 1'b1;
               bus.M_rdata_in  = memRdata;
               rvPending       = 1'b0;
            end else begin
               rvCnt--;
            end
         end else if (bus.M_req_out && memOn) begin
            if (gntCnt == gntDelay) begin
               bus.M_gnt_in = 1'b1;
               gntCnt       = 0;
               rvPending    = 1'b1;
               rvCnt        = rvDelay - 1;
            end else begin
               gntCnt++;
            end
         end else begin
            gntCnt = 0;
         end
      end
   end

   assert property (@(posedge CLK) !(bus.M_gnt_in && bus.M_rvalid_in))
      else $error("[TB] FAIL gntRvalidOverlap");

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Counts busy cycles from the request until busy drops; returns at the DONE-cycle negedge.
   task automatic runUntilDone(input bit isD, output int nBusy);
      nBusy = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge CLK);
         if ((isD ? bus.D_busy_out : bus.I_busy_out) == 1'b1) nBusy++;
         else return;
      end
      checks++;
      failures++;
      $display("[TB] FAIL busyNeverDropped: got busy after 300 cycles expected drop");
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      int nBusy;
      @(posedge CLK);
      #1;
      gntDelay = v.gd;
      rvDelay  = v.rd;
      memRdata = v.memData;
      if (v.isD) begin
         bus.D_req_in   = 1'b1;
         bus.D_wr_in    = v.wr;
         bus.D_be_in    = v.be;
         bus.D_addr_in  = v.addr;
         bus.D_wdata_in = v.wdata;
      end else begin
         bus.I_req_in  = 1'b1;
         bus.I_addr_in = v.addr;
      end
      runUntilDone(v.isD, nBusy);
      checkOutput({tag, ".busyCycles"}, 32'(nBusy), 32'(v.expBusy));
      checkOutput({tag, ".rdata"}, v.isD ? bus.D_rdata_out : bus.I_rdata_out, v.expRdata);
      checkOutput({tag, ".M_wr"}, 32'(bus.M_wr_out), 32'(v.expWr));
      checkOutput({tag, ".M_be"}, 32'(bus.M_be_out), 32'(v.expBe));
      checkOutput({tag, ".M_addr"}, bus.M_addr_out, v.expAddr);
      checkOutput({tag, ".M_wdata"}, bus.M_wdata_out, v.expWdata);
      @(posedge CLK);
      #1;
      bus.I_req_in = 1'b0;
      bus.D_req_in = 1'b0;
   endtask

   initial begin
      int nBusy;
      int dGrants;
      int reqCycles;
      int unstable;
      bit iDone;
      bit finished;

      vecs[0] = '{isD:1'b0, wr:1'b0, be:4'h0, addr:32'h0000_0100, wdata:32'h0, memData:32'h0050_0093,
                  gd:0, rd:1, expBusy:3, expRdata:32'h0050_0093, expWr:1'b0, expBe:4'hF,
                  expAddr:32'h0000_0100, expWdata:32'h0};
      vecs[1] = '{isD:1'b1, wr:1'b0, be:4'hF, addr:32'h0000_2000, wdata:32'hAAAA_5555, memData:32'h1234_5678,
                  gd:1, rd:2, expBusy:5, expRdata:32'h1234_5678, expWr:1'b0, expBe:4'hF,
                  expAddr:32'h0000_2000, expWdata:32'hAAAA_5555};
      vecs[2] = '{isD:1'b1, wr:1'b1, be:4'b0011, addr:32'h0000_2004, wdata:32'hDEAD_BEEF, memData:32'hFFFF_FFFF,
                  gd:0, rd:1, expBusy:3, expRdata:32'h1234_5678, expWr:1'b1, expBe:4'b0011,
                  expAddr:32'h0000_2004, expWdata:32'hDEAD_BEEF};
      vecs[3] = '{isD:1'b0, wr:1'b0, be:4'h0, addr:32'h0000_0104, wdata:32'h0, memData:32'hCAFE_F00D,
                  gd:2, rd:3, expBusy:7, expRdata:32'hCAFE_F00D, expWr:1'b0, expBe:4'hF,
                  expAddr:32'h0000_0104, expWdata:32'h0};
      vecs[4] = '{isD:1'b1, wr:1'b0, be:4'b0101, addr:32'h0000_3000, wdata:32'h0, memData:32'h0BAD_F00D,
                  gd:0, rd:4, expBusy:6, expRdata:32'h0BAD_F00D, expWr:1'b0, expBe:4'b0101,
                  expAddr:32'h0000_3000, expWdata:32'h0};

      RSTn           = 1'b0;
      bus.I_req_in   = 1'b1;
      bus.I_addr_in  = 32'h0000_0F00;
      bus.D_req_in   = 1'b1;
      bus.D_wr_in    = 1'b1;
      bus.D_be_in    = 4'hF;
      bus.D_addr_in  = 32'h0000_0F04;
      bus.D_wdata_in = 32'h1111_2222;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checkOutput("rst.I_busy", 32'(bus.I_busy_out), 32'h0);
      checkOutput("rst.D_busy", 32'(bus.D_busy_out), 32'h0);
      checkOutput("rst.M_req", 32'(bus.M_req_out), 32'h0);
      checkOutput("rst.M_wr", 32'(bus.M_wr_out), 32'h0);
      checkOutput("rst.M_be", 32'(bus.M_be_out), 32'h0);
      checkOutput("rst.M_addr", bus.M_addr_out, 32'h0);
      checkOutput("rst.M_wdata", bus.M_wdata_out, 32'h0);
      checkOutput("rst.I_rdata", bus.I_rdata_out, 32'h0);
      checkOutput("rst.D_rdata", bus.D_rdata_out, 32'h0);
      checkOutput("rst.err", 32'(bus.ERR_timeout_out), 32'h0);
      @(posedge CLK);
      #1;
      bus.I_req_in = 1'b0;
      bus.D_req_in = 1'b0;
      RSTn         = 1'b1;

      for (int i = 0; i < 5; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

      // Both ports requesting with data back-to-back: four data grants, then fetch is forced.
      @(posedge CLK);
      #1;
      gntDelay = 0;
      rvDelay  = 1;
      memRdata = 32'h1111_0000;
      bus.I_req_in  = 1'b1;
      bus.I_addr_in = 32'h0000_0200;
      bus.D_req_in  = 1'b1;
      bus.D_wr_in   = 1'b0;
      bus.D_be_in   = 4'hF;
      bus.D_addr_in = 32'h0000_2100;
      dGrants = 0;
      iDone   = 1'b0;
      for (int c = 0; c < 200 && !iDone; c++) begin
         @(negedge CLK);
         if (!bus.D_busy_out) dGrants++;
         if (!bus.I_busy_out) iDone = 1'b1;
      end
      checkOutput("starve.iDone", 32'(iDone), 32'h1);
      checkOutput("starve.dGrantsBeforeI", 32'(dGrants), 32'd4);
      checkOutput("starve.I_rdata", bus.I_rdata_out, 32'h1111_0000);
      checkOutput("starve.D_rdata", bus.D_rdata_out, 32'h1111_0000);
      checkOutput("starve.M_addr", bus.M_addr_out, 32'h0000_0200);
      @(posedge CLK);
      #1;
      bus.I_req_in = 1'b0;
      bus.D_req_in = 1'b0;

      // Reset while waiting for load data; the late completion must be ignored.
      @(posedge CLK);
      #1;
      gntDelay = 0;
      rvDelay  = 5;
      memRdata = 32'h7777_8888;
      bus.D_req_in  = 1'b1;
      bus.D_wr_in   = 1'b0;
      bus.D_addr_in = 32'h0000_6000;
      repeat (3) begin
         @(posedge CLK);
         #1;
      end
      RSTn = 1'b0;
      @(negedge CLK);
      checkOutput("rstWait.busyForced", 32'(bus.D_busy_out), 32'h0);
      @(posedge CLK);
      #1;
      bus.D_req_in = 1'b0;
      @(negedge CLK);
      checkOutput("rstWait.M_req", 32'(bus.M_req_out), 32'h0);
      checkOutput("rstWait.D_rdata", bus.D_rdata_out, 32'h0);
      checkOutput("rstWait.I_rdata", bus.I_rdata_out, 32'h0);
      @(posedge CLK);
      #1;
      RSTn = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checkOutput("rstWait.lateRvalidD_rdata", bus.D_rdata_out, 32'h0);
      checkOutput("rstWait.lateRvalidM_req", 32'(bus.M_req_out), 32'h0);

      // Grant delayed 3 cycles, completion 5 cycles later; inputs change but M fields must hold.
      @(posedge CLK);
      #1;
      gntDelay = 3;
      rvDelay  = 5;
      memRdata = 32'h9999_0000;
      bus.D_req_in   = 1'b1;
      bus.D_wr_in    = 1'b1;
      bus.D_be_in    = 4'b1100;
      bus.D_addr_in  = 32'h0000_4000;
      bus.D_wdata_in = 32'h5A5A_5A5A;
      nBusy     = 0;
      reqCycles = 0;
      unstable  = 0;
      finished  = 1'b0;
      for (int c = 0; c < 100 && !finished; c++) begin
         @(negedge CLK);
         if (bus.M_req_out) begin
            reqCycles++;
            if (bus.M_addr_out !== 32'h0000_4000 || bus.M_wdata_out !== 32'h5A5A_5A5A) unstable++;
            bus.D_addr_in  = 32'h0000_4444;
            bus.D_wdata_in = 32'hFFFF_0000;
         end
         if (bus.D_busy_out) nBusy++;
         else finished = 1'b1;
      end
      checkOutput("slowGnt.finished", 32'(finished), 32'h1);
      checkOutput("slowGnt.busyCycles", 32'(nBusy), 32'd10);
      checkOutput("slowGnt.reqCycles", 32'(reqCycles), 32'd4);
      checkOutput("slowGnt.unstable", 32'(unstable), 32'd0);
      checkOutput("slowGnt.M_be", 32'(bus.M_be_out), 32'h0000_000C);
      checkOutput("slowGnt.D_rdata", bus.D_rdata_out, 32'h0);
      @(posedge CLK);
      #1;
      bus.D_req_in = 1'b0;

      applyStimulus(vecs[1], "preTmo");
      checkOutput("preTmo.err", 32'(bus.ERR_timeout_out), 32'h0);

      // Memory never grants: abort after TIMEOUT cycles in REQ_D.
      @(posedge CLK);
      #1;
      memOn = 1'b0;
      bus.D_req_in  = 1'b1;
      bus.D_wr_in   = 1'b0;
      bus.D_addr_in = 32'h0000_5000;
      runUntilDone(1'b1, nBusy);
      checkOutput("tmo.busyCycles", 32'(nBusy), 32'd65);
      checkOutput("tmo.err", 32'(bus.ERR_timeout_out), 32'h1);
      checkOutput("tmo.D_rdata", bus.D_rdata_out, 32'h0);
      checkOutput("tmo.M_req", 32'(bus.M_req_out), 32'h0);
      @(posedge CLK);
      #1;
      bus.D_req_in = 1'b0;
      memOn = 1'b1;

      applyStimulus(vecs[3], "postTmo");
      checkOutput("postTmo.errSticky", 32'(bus.ERR_timeout_out), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
